// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage, sitting directly upstream of the fetch/decode
// pipeline register. It owns the PC and keeps at most one instruction-cache
// request outstanding, so it tolerates any cache latency. A returned
// instruction is buffered while decode is stalled. Fetches on the wrong path
// are squashed when a branch or jump redirect arrives.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   en           in   decode can accept an instruction this cycle
//   redirect     in   taken branch/jump resolved downstream
//   redirect_pc  in   redirect target (low two bits ignored)
//   req_valid    out  cache request valid
//   req_addr     out  cache request address (always the current PC)
//   req_ready    in   cache accepts the request
//   resp_valid   in   cache returns an instruction
//   resp_data    in   returned instruction word
//   valid_f      out  read_data_f holds a valid instruction for decode
//   read_data_f  out  instruction word (zero when valid_f is low)
//   PC_f         out  address of that instruction
//   PCPlus4_f    out  PC_f + 4, wrapping modulo 2^DATA_WIDTH
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  req_valid,
    output logic [DATA_WIDTH-1:0] req_addr,
    input  logic                  req_ready,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_data,
    output logic                  valid_f,
    output logic [DATA_WIDTH-1:0] read_data_f,
    output logic [DATA_WIDTH-1:0] PC_f,
    output logic [DATA_WIDTH-1:0] PCPlus4_f
);

    // REQ : presenting a request for r_pc
    // WAIT: request accepted, waiting for its response
    // HOLD: response buffered in r_hold while decode is stalled
    // DROP: redirected while a response is still in flight; swallow it
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] w_hold_nxt;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_redir_pc;

    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
    assign w_redir_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    assign req_addr  = r_pc;
    assign PC_f      = r_pc;
    assign PCPlus4_f = w_pc_plus4;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_REQ: begin
                // A redirect suppresses req_valid, so no handshake can occur
                if (redirect) begin
                    w_pc_nxt = w_redir_pc;
                end else if (req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid && redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_REQ;
                end else if (resp_valid && en) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = S_REQ;
                end else if (resp_valid) begin
                    w_hold_nxt  = resp_data;
                    w_state_nxt = S_HOLD;
                end else if (redirect) begin
                    // The in-flight response belongs to the old path
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_REQ;
                end else if (en) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                // Latest redirect target wins; the response is discarded
                if (redirect) begin
                    w_pc_nxt = w_redir_pc;
                end
                if (resp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Output logic
    always_comb begin
        req_valid   = 1'b0;
        valid_f     = 1'b0;
        read_data_f = '0;
        case (r_state)
            S_REQ: begin
                req_valid = !redirect;
            end
            S_WAIT: begin
                // Cache response passes straight through when decode is ready
                if (resp_valid && !redirect && en) begin
                    valid_f     = 1'b1;
                    read_data_f = resp_data;
                end
            end
            S_HOLD: begin
                if (!redirect) begin
                    valid_f     = 1'b1;
                    read_data_f = r_hold;
                end
            end
            default: begin
                valid_f = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The stimulus plays the cache by hand, cycle
// by cycle. Each instruction that decode should consume is pushed to a
// scoreboard when its request is accepted. A monitor pops one entry on every
// cycle with valid_f && en and compares PC_f, PCPlus4_f and read_data_f.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          en;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic          req_valid;
    logic [DW-1:0] req_addr;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          valid_f;
    logic [DW-1:0] read_data_f;
    logic [DW-1:0] PC_f;
    logic [DW-1:0] PCPlus4_f;

    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_unit #(
        .DATA_WIDTH (DW),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .valid_f     (valid_f),
        .read_data_f (read_data_f),
        .PC_f        (PC_f),
        .PCPlus4_f   (PCPlus4_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] pc, input logic [DW-1:0] data);
        sb.push_back('{pc: pc, data: data});
    endtask

    // Check the outputs of the current cycle at the falling edge, then move to
    // just after the next rising edge where the next cycle's inputs are driven.
    task automatic cyc(input string tag, input logic rv, input logic [DW-1:0] ra,
                       input logic vf, input logic [DW-1:0] rd);
        @(negedge clk);
        chk({tag, ".req_valid"}, {31'd0, req_valid}, {31'd0, rv});
        chk({tag, ".req_addr"}, req_addr, ra);
        chk({tag, ".valid_f"}, {31'd0, valid_f}, {31'd0, vf});
        chk({tag, ".read_data_f"}, read_data_f, rd);
        @(posedge clk);
        #1;
    endtask

    // Cache hit with en=1: request cycle then response cycle
    task automatic hit(input string tag, input logic [DW-1:0] addr, input logic [DW-1:0] data);
        req_ready = 1'b1;
        push_exp(addr, data);
        cyc({tag, "_req"}, 1'b1, addr, 1'b0, '0);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = data;
        cyc({tag, "_resp"}, 1'b0, addr, 1'b1, data);
        resp_valid = 1'b0;
        resp_data  = '0;
    endtask

    // Consumption monitor
    always @(negedge clk) begin
        if (!rst && valid_f && en) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_delivery", PC_f, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_PC_f", PC_f, mon_e.pc);
                chk("sb_PCPlus4_f", PCPlus4_f, mon_e.pc + 32'd4);
                chk("sb_read_data_f", read_data_f, mon_e.data);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // First cycle after reset
        @(negedge clk);
        chk("rst_PC_f", PC_f, 32'h0);
        chk("rst_PCPlus4_f", PCPlus4_f, 32'h4);
        @(posedge clk);
        #1;

        // Back-to-back hits: one instruction every two cycles
        hit("hit0", 32'h0, 32'h1000_0013);
        hit("hit1", 32'h4, 32'h1000_0113);
        hit("hit2", 32'h8, 32'h1000_0213);

        // Response arrives while decode is stalled, held for three cycles
        req_ready = 1'b1;
        push_exp(32'hC, 32'h0050_0093);
        cyc("h_req", 1'b1, 32'hC, 1'b0, '0);
        req_ready = 1'b0;
        cyc("h_wait", 1'b0, 32'hC, 1'b0, '0);
        resp_valid = 1'b1;
        resp_data  = 32'h0050_0093;
        en         = 1'b0;
        cyc("h_resp", 1'b0, 32'hC, 1'b0, '0);
        resp_valid = 1'b0;
        resp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            cyc("h_hold", 1'b0, 32'hC, 1'b1, 32'h0050_0093);
        end
        en = 1'b1;
        cyc("h_take", 1'b0, 32'hC, 1'b1, 32'h0050_0093);
        resp_data = '0;

        // Redirect while waiting (latency 4), re-redirect in DROP
        req_ready = 1'b1;
        cyc("d_req", 1'b1, 32'h10, 1'b0, '0);
        req_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        cyc("d_wait", 1'b0, 32'h10, 1'b0, '0);
        redirect_pc = 32'h100;
        cyc("d_drop1", 1'b0, 32'h80, 1'b0, '0);
        redirect = 1'b0;
        cyc("d_drop2", 1'b0, 32'h100, 1'b0, '0);
        resp_valid = 1'b1;
        resp_data  = 32'h1234_5678;
        cyc("d_late", 1'b0, 32'h100, 1'b0, '0);
        resp_valid = 1'b0;

        // Redirect to an unaligned target coincident with the response
        req_ready = 1'b1;
        cyc("r_req", 1'b1, 32'h100, 1'b0, '0);
        req_ready   = 1'b0;
        resp_valid  = 1'b1;
        resp_data   = 32'hCAFE_0013;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        cyc("r_coin", 1'b0, 32'h100, 1'b0, '0);
        resp_valid = 1'b0;
        redirect   = 1'b0;

        // Redirect in REQ suppresses the request even with req_ready high
        req_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFD;
        cyc("q_redir", 1'b0, 32'h200, 1'b0, '0);
        redirect = 1'b0;

        // Top of address space: PCPlus4_f wraps to zero
        hit("wrap", 32'hFFFF_FFFC, 32'h0000_0073);
        @(negedge clk);
        chk("wrap_next_addr", req_addr, 32'h0);
        @(posedge clk);
        #1;

        // Redirect has priority over en in HOLD
        req_ready = 1'b1;
        cyc("p_req", 1'b1, 32'h0, 1'b0, '0);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0011;
        en         = 1'b0;
        cyc("p_resp", 1'b0, 32'h0, 1'b0, '0);
        resp_valid = 1'b0;
        cyc("p_hold", 1'b0, 32'h0, 1'b1, 32'h0000_0011);
        en          = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        cyc("p_redir", 1'b0, 32'h0, 1'b0, '0);
        redirect = 1'b0;

        // Cache back-pressure, then reset mid-stall
        req_ready = 1'b0;
        cyc("s1", 1'b1, 32'h40, 1'b0, '0);
        cyc("s2", 1'b1, 32'h40, 1'b0, '0);
        rst = 1'b1;
        cyc("s3", 1'b1, 32'h40, 1'b0, '0);
        rst = 1'b0;
        cyc("s4", 1'b1, 32'h0, 1'b0, '0);
        cyc("s5", 1'b1, 32'h0, 1'b0, '0);

        // Normal fetch resumes after reset
        hit("post", 32'h0, 32'h0010_0513);
        @(negedge clk);
        chk("post_next_addr", req_addr, 32'h4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
